// File: rtl/spi_slave_usi_bridge.sv
// spi_slave_usi_bridge
//   Lets an external SPI master (mode 0, MSB first) drive the Usi bus as a
//   bus master. SCK/CS/MOSI are oversampled on iSCLK, and frames are decoded
//   as cmd(8) + address(16) + data. The data phase issues write strobes or
//   address-driven reads with prefetch.
// Ports:
//   iSCLK, iSRST          system clock, async active-low reset
//   iSpiSck/Cs/Mosi       SPI inputs (asynchronous to iSCLK)
//   oSpiMiso, oSpiMisoOe  SPI data out and its enable
//   oMUsiWd/Adrs/WEd      Usi write data, address, one-cycle write strobe
//   iMUsiRd, iMUsiREd     Usi read data and per-slave read-valid bits
//   oMUsiSel              bus ownership request during valid frames
//   oRdErr                sticky read-timeout flag (cleared by cmd 8'h9F)
module spi_slave_usi_bridge #(
  parameter int         pUsiBusWidth     = 16,
  parameter int         pBusBlockConnect = 1,
  parameter logic [7:0] pRdTimeout       = 8'd48
) (
  input  logic                        iSCLK,
  input  logic                        iSRST,
  input  logic                        iSpiSck,
  input  logic                        iSpiCs,
  input  logic                        iSpiMosi,
  output logic                        oSpiMiso,
  output logic                        oSpiMisoOe,
  output logic [31:0]                 oMUsiWd,
  output logic [pUsiBusWidth-1:0]     oMUsiAdrs,
  output logic                        oMUsiWEd,
  input  logic [31:0]                 iMUsiRd,
  input  logic [pBusBlockConnect-1:0] iMUsiREd,
  output logic                        oMUsiSel,
  output logic                        oRdErr
);

  typedef enum logic [2:0] {IDLE, CMD, ADR, WDATA, DUMMY, RDATA, DISCARD} state_t;

  state_t state, state_nx;

  logic [2:0]  sck_s, cs_s;
  logic [1:0]  mosi_s;
  logic        sck_rise, sck_fall, cs_hi, cs_fall;
  logic [30:0] shreg;
  logic [31:0] sin;
  logic [4:0]  cnt;
  logic        is_rd;
  logic        busy;
  logic [7:0]  tcnt;
  logic [31:0] rdbuf;
  logic [31:0] miso_sr;
  logic        load_pend;

  // CS sync resets low so that a reset taken while CS is already low does
  // not look like a fresh CS fall: the block waits for a real falling edge.
  always_ff @(posedge iSCLK or negedge iSRST) begin
    if (!iSRST) begin
      sck_s  <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], iSpiSck};
      cs_s   <= {cs_s[1:0], iSpiCs};
      mosi_s <= {mosi_s[0], iSpiMosi};
    end
  end

  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign cs_hi    = cs_s[1];
  assign cs_fall  = cs_s[2] & ~cs_s[1];
  assign sin      = {shreg, mosi_s[1]};

  always_ff @(posedge iSCLK or negedge iSRST) begin
    if (!iSRST) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_hi) state_nx = IDLE;
    else begin
      case (state)
        IDLE:  if (cs_fall) state_nx = CMD;
        CMD:   if (sck_rise && cnt == 5'd7)
                 state_nx = (sin[7:0] == 8'h02 || sin[7:0] == 8'h0B) ? ADR : DISCARD;
        ADR:   if (sck_rise && cnt == 5'd15) state_nx = is_rd ? DUMMY : WDATA;
        DUMMY: if (sck_rise && cnt == 5'd7) state_nx = RDATA;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge iSCLK or negedge iSRST) begin
    if (!iSRST) begin
      shreg     <= '0;
      cnt       <= '0;
      is_rd     <= 1'b0;
      busy      <= 1'b0;
      tcnt      <= '0;
      rdbuf     <= '0;
      miso_sr   <= '0;
      load_pend <= 1'b0;
      oMUsiWd   <= '0;
      oMUsiAdrs <= '0;
      oMUsiWEd  <= 1'b0;
      oRdErr    <= 1'b0;
    end else begin
      oMUsiWEd <= 1'b0;
      // bit counter restarts at every field boundary; 5 bits wrap per word
      if (state != state_nx) cnt <= '0;
      else if (sck_rise)     cnt <= cnt + 5'd1;
      if (sck_rise) shreg <= sin[30:0];
      // post-increment after the strobe cycle so Adrs is stable while WEd high
      if (oMUsiWEd) oMUsiAdrs <= oMUsiAdrs + pUsiBusWidth'(1);

      if (cs_hi) begin
        // abandon any in-flight fetch; a late REd then has no effect
        busy      <= 1'b0;
        load_pend <= 1'b0;
        miso_sr   <= '0;
      end else begin
        if (busy) begin
          if (|iMUsiREd) begin
            rdbuf <= iMUsiRd;
            busy  <= 1'b0;
          end else if (tcnt == pRdTimeout - 8'd1) begin
            rdbuf  <= '0;
            oRdErr <= 1'b1;
            busy   <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        case (state)
          CMD: if (sck_rise && cnt == 5'd7) begin
            is_rd <= (sin[7:0] == 8'h0B);
            if (sin[7:0] == 8'h9F) oRdErr <= 1'b0;
          end
          ADR: if (sck_rise && cnt == 5'd15) begin
            oMUsiAdrs <= sin[pUsiBusWidth-1:0];
            if (is_rd) begin
              busy <= 1'b1;
              tcnt <= '0;
            end
          end
          WDATA: if (sck_rise && cnt == 5'd31) begin
            oMUsiWd  <= sin;
            oMUsiWEd <= 1'b1;
          end
          DUMMY: if (sck_rise && cnt == 5'd7) load_pend <= 1'b1;
          RDATA: begin
            // 8th rising edge of a word (bit 24): step address, prefetch next
            if (sck_rise && cnt == 5'd7) begin
              oMUsiAdrs <= oMUsiAdrs + pUsiBusWidth'(1);
              busy      <= 1'b1;
              tcnt      <= '0;
            end
            if (sck_rise && cnt == 5'd31) load_pend <= 1'b1;
            if (sck_fall) begin
              if (load_pend) begin
                miso_sr   <= rdbuf;
                load_pend <= 1'b0;
              end else begin
                miso_sr <= {miso_sr[30:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign oSpiMiso   = (state == RDATA) & miso_sr[31];
  assign oSpiMisoOe = (state != IDLE);
  assign oMUsiSel   = (state == ADR) || (state == WDATA) ||
                      (state == DUMMY) || (state == RDATA);

endmodule

// File: tb/tb_spi_slave_usi_bridge.sv
// Directed bench for spi_slave_usi_bridge: write, read with a delayed slave,
// abort, read timeout and clear, bad command, async reset mid-frame.
module tb_spi_slave_usi_bridge;

  logic        iSCLK = 1'b0;
  logic        iSRST;
  logic        iSpiSck, iSpiCs, iSpiMosi;
  logic        oSpiMiso, oSpiMisoOe;
  logic [31:0] oMUsiWd;
  logic [15:0] oMUsiAdrs;
  logic        oMUsiWEd;
  logic [31:0] iMUsiRd;
  logic [0:0]  iMUsiREd;
  logic        oMUsiSel, oRdErr;

  int checks = 0;
  int errors = 0;

  spi_slave_usi_bridge dut (
    .iSCLK(iSCLK), .iSRST(iSRST), .iSpiSck(iSpiSck), .iSpiCs(iSpiCs),
    .iSpiMosi(iSpiMosi), .oSpiMiso(oSpiMiso), .oSpiMisoOe(oSpiMisoOe),
    .oMUsiWd(oMUsiWd), .oMUsiAdrs(oMUsiAdrs), .oMUsiWEd(oMUsiWEd),
    .iMUsiRd(iMUsiRd), .iMUsiREd(iMUsiREd), .oMUsiSel(oMUsiSel), .oRdErr(oRdErr)
  );

  always #5 iSCLK = ~iSCLK;

  // write strobe recorder
  int          wcnt = 0;
  logic [15:0] w_adr [16];
  logic [31:0] w_dat [16];
  always @(negedge iSCLK) begin
    if (oMUsiWEd === 1'b1) begin
      w_adr[wcnt % 16] = oMUsiAdrs;
      w_dat[wcnt % 16] = oMUsiWd;
      wcnt++;
    end
  end

  // Usi slave model: REd pulse 3 cycles after each address change
  logic        rd_model_en = 1'b0;
  logic [15:0] last_adrs = 16'h0;
  int          dly = 0;
  initial begin
    iMUsiREd = 1'b0;
    iMUsiRd  = 32'h0;
  end
  always @(negedge iSCLK) begin
    iMUsiREd = 1'b0;
    if (oMUsiAdrs !== last_adrs) begin
      last_adrs = oMUsiAdrs;
      dly = 3;
    end else if (dly != 0) begin
      dly--;
      if (dly == 0 && rd_model_en) begin
        iMUsiREd = 1'b1;
        case (oMUsiAdrs)
          16'h0020: iMUsiRd = 32'h12345678;
          16'h0021: iMUsiRd = 32'h9ABCDEF0;
          default:  iMUsiRd = 32'h0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge iSCLK);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      iSpiMosi = tx[i];
      clk(8);
      rx[i] = oSpiMiso;
      iSpiSck = 1'b1;
      clk(8);
      iSpiSck = 1'b0;
    end
  endtask

  task automatic cs_low();
    iSpiCs = 1'b0;
    clk(6);
  endtask

  task automatic cs_high();
    clk(4);
    iSpiCs = 1'b1;
    clk(10);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [31:0] w0, w1;
    int          base;
    logic [7:0]  wr_frame [11];
    wr_frame = '{8'h02, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                 8'h01, 8'h02, 8'h03, 8'h04};

    iSRST = 1'b0; iSpiCs = 1'b1; iSpiSck = 1'b0; iSpiMosi = 1'b0;
    clk(3);
    check("rst_miso", {31'b0, oSpiMiso}, 32'h0);
    check("rst_oe",   {31'b0, oSpiMisoOe}, 32'h0);
    check("rst_wd",   oMUsiWd, 32'h0);
    check("rst_adrs", {16'h0, oMUsiAdrs}, 32'h0);
    check("rst_wed",  {31'b0, oMUsiWEd}, 32'h0);
    check("rst_sel",  {31'b0, oMUsiSel}, 32'h0);
    check("rst_rderr",{31'b0, oRdErr}, 32'h0);
    iSRST = 1'b1;
    clk(5);

    // ---- write: two words ----
    base = wcnt;
    iSpiCs = 1'b0;
    clk(2);
    check("cs_lat_oe_early", {31'b0, oSpiMisoOe}, 32'h0);
    clk(1);
    check("cs_lat_oe", {31'b0, oSpiMisoOe}, 32'h1);
    clk(3);
    for (int b = 0; b < 11; b++) begin
      spi_xfer(wr_frame[b], rx);
      if (b >= 3) check("wr_sel", {31'b0, oMUsiSel}, 32'h1);
    end
    cs_high();
    check("wr_cnt",  wcnt - base, 2);
    check("wr_adr0", {16'h0, w_adr[base % 16]}, 32'h0010);
    check("wr_dat0", w_dat[base % 16], 32'hDEADBEEF);
    check("wr_adr1", {16'h0, w_adr[(base + 1) % 16]}, 32'h0011);
    check("wr_dat1", w_dat[(base + 1) % 16], 32'h01020304);
    check("wr_sel_off", {31'b0, oMUsiSel}, 32'h0);
    check("wr_oe_off",  {31'b0, oSpiMisoOe}, 32'h0);

    // ---- read: two words through the slave model ----
    rd_model_en = 1'b1;
    cs_low();
    spi_xfer(8'h0B, rx); check("rd_hdr0", {24'h0, rx}, 32'h0);
    spi_xfer(8'h00, rx); check("rd_hdr1", {24'h0, rx}, 32'h0);
    spi_xfer(8'h20, rx); check("rd_hdr2", {24'h0, rx}, 32'h0);
    check("rd_adrs0", {16'h0, oMUsiAdrs}, 32'h0020);
    spi_xfer(8'h00, rx); check("rd_dummy", {24'h0, rx}, 32'h0);
    for (int b = 0; b < 4; b++) begin
      spi_xfer(8'h00, rx);
      w0 = {w0[23:0], rx};
      if (b == 0) check("rd_adrs1", {16'h0, oMUsiAdrs}, 32'h0021);
    end
    for (int b = 0; b < 4; b++) begin
      spi_xfer(8'h00, rx);
      w1 = {w1[23:0], rx};
    end
    check("rd_word0", w0, 32'h12345678);
    check("rd_word1", w1, 32'h9ABCDEF0);
    check("rd_sel", {31'b0, oMUsiSel}, 32'h1);
    cs_high();
    check("rd_rderr", {31'b0, oRdErr}, 32'h0);
    rd_model_en = 1'b0;

    // ---- abort mid-word, then a fresh write ----
    base = wcnt;
    cs_low();
    spi_xfer(8'h02, rx); spi_xfer(8'h00, rx); spi_xfer(8'h05, rx);
    spi_xfer(8'hAA, rx); spi_xfer(8'hBB, rx);
    cs_high();
    check("abort_cnt", wcnt - base, 0);
    cs_low();
    spi_xfer(8'h02, rx); spi_xfer(8'h00, rx); spi_xfer(8'h07, rx);
    spi_xfer(8'h11, rx); spi_xfer(8'h22, rx); spi_xfer(8'h33, rx); spi_xfer(8'h44, rx);
    cs_high();
    check("abort_new_cnt", wcnt - base, 1);
    check("abort_new_adr", {16'h0, w_adr[base % 16]}, 32'h0007);
    check("abort_new_dat", w_dat[base % 16], 32'h11223344);

    // ---- read timeout, then clear with 9F ----
    cs_low();
    spi_xfer(8'h0B, rx); spi_xfer(8'h00, rx); spi_xfer(8'h40, rx); spi_xfer(8'h00, rx);
    for (int b = 0; b < 4; b++) begin
      spi_xfer(8'h00, rx);
      w0 = {w0[23:0], rx};
    end
    check("to_word", w0, 32'h0);
    check("to_rderr", {31'b0, oRdErr}, 32'h1);
    cs_high();
    check("to_rderr_sticky", {31'b0, oRdErr}, 32'h1);
    cs_low();
    spi_xfer(8'h9F, rx);
    check("clr_sel", {31'b0, oMUsiSel}, 32'h0);
    cs_high();
    check("clr_rderr", {31'b0, oRdErr}, 32'h0);

    // ---- bad command ----
    base = wcnt;
    cs_low();
    spi_xfer(8'h55, rx);
    check("bad_sel", {31'b0, oMUsiSel}, 32'h0);
    w0 = 32'h0;
    for (int b = 0; b < 6; b++) begin
      spi_xfer(8'hA5, rx);
      w0 = w0 | {24'h0, rx};
    end
    check("bad_miso", w0, 32'h0);
    check("bad_sel2", {31'b0, oMUsiSel}, 32'h0);
    cs_high();
    check("bad_wed", wcnt - base, 0);

    // ---- async reset mid-address ----
    base = wcnt;
    cs_low();
    spi_xfer(8'h02, rx); spi_xfer(8'h00, rx);
    check("prerst_sel", {31'b0, oMUsiSel}, 32'h1);
    iSRST = 1'b0;
    clk(2);
    check("mid_rst_oe",   {31'b0, oSpiMisoOe}, 32'h0);
    check("mid_rst_sel",  {31'b0, oMUsiSel}, 32'h0);
    check("mid_rst_adrs", {16'h0, oMUsiAdrs}, 32'h0);
    check("mid_rst_wd",   oMUsiWd, 32'h0);
    check("mid_rst_misc", {29'b0, oSpiMiso, oMUsiWEd, oRdErr}, 32'h0);
    iSRST = 1'b1;
    clk(3);
    spi_xfer(8'h08, rx);
    for (int b = 0; b < 4; b++) spi_xfer(8'h5A, rx);
    check("post_rst_idle", {31'b0, oSpiMisoOe}, 32'h0);
    cs_high();
    check("post_rst_nowed", wcnt - base, 0);
    cs_low();
    spi_xfer(8'h02, rx); spi_xfer(8'h00, rx); spi_xfer(8'h30, rx);
    spi_xfer(8'hCA, rx); spi_xfer(8'hFE, rx); spi_xfer(8'hBA, rx); spi_xfer(8'hBE, rx);
    cs_high();
    check("post_rst_cnt", wcnt - base, 1);
    check("post_rst_adr", {16'h0, w_adr[base % 16]}, 32'h0030);
    check("post_rst_dat", w_dat[base % 16], 32'hCAFEBABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
